// File: rtl/cpu8_pkg.sv
// Shared types and constants for the 8-bit accumulator CPU.
package cpu8_pkg;

   // Instruction opcodes carried in IR[7:4]; codes 0x9-0xD are unused and behave as NOP
   typedef enum logic [3:0] {
      OP_NOP = 4'h0,
      OP_LDA = 4'h1,
      OP_ADD = 4'h2,
      OP_SUB = 4'h3,
      OP_STA = 4'h4,
      OP_LDI = 4'h5,
      OP_JMP = 4'h6,
      OP_JC  = 4'h7,
      OP_JZ  = 4'h8,
      OP_OUT = 4'hE,
      OP_HLT = 4'hF
   } opcode_e;

   // Microstep within an instruction; every instruction runs T0..T4
   typedef enum logic [2:0] {
      T0 = 3'd0,
      T1 = 3'd1,
      T2 = 3'd2,
      T3 = 3'd3,
      T4 = 3'd4
   } tstate_e;

   localparam tstate_e T_FIRST = T0;
   localparam tstate_e T_LAST  = T4;

   // 16-byte RAM image, element i is the byte at address i
   typedef logic [15:0][7:0] ram_image_t;

   // Counter program: OUT, ADD 15, JMP 0, with the constant 1 at address 15
   localparam ram_image_t RAM_INIT_DEFAULT = {
      8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
      8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h60, 8'h2F, 8'hE0
   };

endpackage

// File: rtl/cpu8_core.sv
// SAP-1 class core: registers, ALU, 16x8 RAM and the five-step microcode sequencer.
module cpu8_core
   import cpu8_pkg::*;
#(
   parameter ram_image_t RAM_INIT = RAM_INIT_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ce,
   output logic [7:0] out_reg
);

   logic [3:0] pc_q, pc_d;
   logic [3:0] mar_q, mar_d;
   logic [7:0] ir_q, ir_d;
   logic [7:0] a_q, a_d;
   logic [7:0] b_q, b_d;
   logic [7:0] out_q, out_d;
   logic       c_q, c_d;
   logic       z_q, z_d;
   logic       halted_q, halted_d;
   tstate_e    t_q, t_d;

   // RAM holds (contents XOR image) so that the power-up all-zero state reads back as the image
   logic [7:0] ram_x [16];
   logic       ram_we;
   logic [7:0] ram_rd;

   logic       step;
   opcode_e    opcode;
   logic [3:0] operand;
   logic [8:0] alu_sum;

   assign step    = ce & ~halted_q;
   assign ram_rd  = ram_x[mar_q] ^ RAM_INIT[mar_q];
   assign opcode  = opcode_e'(ir_q[7:4]);
   assign operand = ir_q[3:0];
   assign alu_sum = (opcode == OP_SUB) ? ({1'b0, a_q} + {1'b0, ~b_q} + 9'd1)
                                       : ({1'b0, a_q} + {1'b0, b_q});
   assign out_reg = out_q;

   // Microcode: execute the current microstep on each enabled step, then advance T
   always_comb begin
      pc_d     = pc_q;
      mar_d    = mar_q;
      ir_d     = ir_q;
      a_d      = a_q;
      b_d      = b_q;
      out_d    = out_q;
      c_d      = c_q;
      z_d      = z_q;
      halted_d = halted_q;
      t_d      = t_q;
      ram_we   = 1'b0;
      if (step) begin
         case (t_q)
            T0: begin
               mar_d = pc_q;
               t_d   = T1;
            end
            T1: begin
               ir_d = ram_rd;
               pc_d = pc_q + 4'd1;
               t_d  = T2;
            end
            T2: begin
               case (opcode)
                  OP_LDA, OP_ADD, OP_SUB, OP_STA: mar_d = operand;
                  OP_LDI: a_d = {4'h0, operand};
                  OP_JMP: pc_d = operand;
                  OP_JC:  if (c_q) pc_d = operand;
                  OP_JZ:  if (z_q) pc_d = operand;
                  OP_OUT: out_d = a_q;
                  OP_HLT: halted_d = 1'b1;
                  default: ;
               endcase
               t_d = T3;
            end
            T3: begin
               case (opcode)
                  OP_LDA:         a_d = ram_rd;
                  OP_ADD, OP_SUB: b_d = ram_rd;
                  OP_STA:         ram_we = 1'b1;
                  default: ;
               endcase
               t_d = T_LAST;
            end
            T4: begin
               if (opcode == OP_ADD || opcode == OP_SUB) begin
                  a_d = alu_sum[7:0];
                  c_d = alu_sum[8];
                  z_d = (alu_sum[7:0] == 8'h00);
               end
               t_d = T_FIRST;
            end
            default: t_d = T_FIRST;
         endcase
      end
   end

   // Architectural state register with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q     <= '0;
         mar_q    <= '0;
         ir_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         out_q    <= '0;
         c_q      <= 1'b0;
         z_q      <= 1'b0;
         halted_q <= 1'b0;
         t_q      <= T_FIRST;
      end else begin
         pc_q     <= pc_d;
         mar_q    <= mar_d;
         ir_q     <= ir_d;
         a_q      <= a_d;
         b_q      <= b_d;
         out_q    <= out_d;
         c_q      <= c_d;
         z_q      <= z_d;
         halted_q <= halted_d;
         t_q      <= t_d;
      end
   end

   // RAM write port for STA; contents survive reset
   always_ff @(posedge clk) begin
      if (ram_we && !rst) begin
         ram_x[mar_q] <= a_q ^ RAM_INIT[mar_q];
      end
   end

endmodule

// File: rtl/cpu8_top.sv
// Board top: button/switch synchronizers, step generation, divider and LED drive.
module cpu8_top
   import cpu8_pkg::*;
#(
   parameter int         DIV_COUNT = 13_500_000,
   parameter ram_image_t RAM_INIT  = RAM_INIT_DEFAULT
) (
   input  logic       clk,
   input  logic       btn1_n,
   input  logic       btn2_n,
   input  logic       slide_switch,
   output logic [5:0] led
);

   localparam int             DIV_W    = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_COUNT - 1);

   logic [1:0]       rst_sync_q, rst_sync_d;
   logic [2:0]       step_sync_q, step_sync_d;
   logic [1:0]       mode_sync_q, mode_sync_d;
   logic [DIV_W-1:0] div_q, div_d;

   logic       rst;
   logic       step_pulse;
   logic       auto_mode;
   logic       div_tick;
   logic       ce;
   logic [7:0] out_reg;

   assign rst        = ~rst_sync_q[1];
   assign step_pulse = step_sync_q[2] & ~step_sync_q[1];
   assign auto_mode  = mode_sync_q[1];
   assign div_tick   = (div_q == DIV_LAST);
   assign ce         = auto_mode ? div_tick : step_pulse;
   assign led        = ~out_reg[5:0];

   // Shift chains for the pins; the step chain keeps one extra stage for falling-edge detection
   always_comb begin
      rst_sync_d  = {rst_sync_q[0], btn1_n};
      step_sync_d = {step_sync_q[1:0], btn2_n};
      mode_sync_d = {mode_sync_q[0], slide_switch};
      div_d       = div_tick ? '0 : div_q + DIV_W'(1);
   end

   // Synchronizer flops are never reset so the reset button itself can propagate
   always_ff @(posedge clk) begin
      rst_sync_q  <= rst_sync_d;
      step_sync_q <= step_sync_d;
      mode_sync_q <= mode_sync_d;
   end

   // Auto-step divider, restarted by reset
   always_ff @(posedge clk) begin
      if (rst) begin
         div_q <= '0;
      end else begin
         div_q <= div_d;
      end
   end

   cpu8_core #(
      .RAM_INIT (RAM_INIT)
   ) u_core (
      .clk     (clk),
      .rst     (rst),
      .ce      (ce),
      .out_reg (out_reg)
   );

endmodule

// File: tb/tb_cpu8_top.sv
// Self-checking bench for cpu8_top: counter program in auto and manual modes, and a halting program.
module tb_cpu8_top;
   import cpu8_pkg::*;

   // LDI 5; SUB 15; JZ 4; JMP 1; HLT; [15] = 1
   localparam ram_image_t HALT_IMAGE = {
      8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
      8'h00, 8'h00, 8'h00, 8'hF0, 8'h61, 8'h84, 8'h3F, 8'h55
   };

   logic       clk = 1'b0;
   logic       btn1_n, btn2_n, slide;
   logic       h_btn1_n, h_btn2_n, h_slide;
   logic [5:0] led, h_led;

   int testCount = 0;
   int failCount = 0;
   int nce;
   int haltCe;

   // ISA-level reference state for the halting program
   logic [7:0] m_ram [16];
   int m_pc, m_a, m_b, m_c, m_z, m_out, m_halted;

   always #5 clk = ~clk;

   cpu8_top #(.DIV_COUNT(1)) dut (
      .clk          (clk),
      .btn1_n       (btn1_n),
      .btn2_n       (btn2_n),
      .slide_switch (slide),
      .led          (led)
   );

   cpu8_top #(.DIV_COUNT(1), .RAM_INIT(HALT_IMAGE)) dut_h (
      .clk          (clk),
      .btn1_n       (h_btn1_n),
      .btn2_n       (h_btn2_n),
      .slide_switch (h_slide),
      .led          (h_led)
   );

   // Count one comparison and report it if it disagrees
   task automatic checkOutput(input string tag, input int actual, input int expected);
      testCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   // Advance n rising edges and settle just after the last one
   task automatic waitClocks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Deliver a number of manual step presses with random press/release widths
   task automatic applyStimulus(input int presses);
      for (int i = 0; i < presses; i++) begin
         btn2_n = 1'b0;
         waitClocks($urandom_range(1, 3));
         btn2_n = 1'b1;
         waitClocks($urandom_range(3, 5));
      end
   endtask

   // Counter program in closed form: OUT written at ce 3+15k with k, A becomes k+1 at ce 10+15k
   function automatic int expOut(input int n);
      return (n < 3) ? 0 : ((n - 3) / 15) % 256;
   endfunction

   function automatic int expAcc(input int n);
      return (n < 10) ? 0 : (((n - 10) / 15) + 1) % 256;
   endfunction

   function automatic int expFlag(input int n);
      return (n >= 10 && expAcc(n) == 0) ? 1 : 0;
   endfunction

   function automatic int ledOf(input int v);
      return (~v) & 63;
   endfunction

   // Instruction-level interpreter; reports the ce on which HLT takes effect
   task automatic runModel(output int hce);
      int         instr;
      int         sum;
      logic [7:0] ir;
      logic [3:0] n;
      for (int i = 0; i < 16; i++) m_ram[i] = HALT_IMAGE[i];
      m_pc = 0; m_a = 0; m_b = 0; m_c = 0; m_z = 0; m_out = 0; m_halted = 0;
      instr = 0;
      hce = 1000;
      while (m_halted == 0 && instr < 200) begin
         ir = m_ram[m_pc];
         n = ir[3:0];
         m_pc = (m_pc + 1) % 16;
         case (ir[7:4])
            4'h1: m_a = m_ram[n];
            4'h2: begin
               m_b = m_ram[n];
               sum = m_a + m_b;
               m_c = (sum > 255) ? 1 : 0;
               m_a = sum % 256;
               m_z = (m_a == 0) ? 1 : 0;
            end
            4'h3: begin
               m_b = m_ram[n];
               sum = m_a + (255 - m_b) + 1;
               m_c = (sum > 255) ? 1 : 0;
               m_a = sum % 256;
               m_z = (m_a == 0) ? 1 : 0;
            end
            4'h4: m_ram[n] = 8'(m_a);
            4'h5: m_a = int'(n);
            4'h6: m_pc = int'(n);
            4'h7: if (m_c != 0) m_pc = int'(n);
            4'h8: if (m_z != 0) m_pc = int'(n);
            4'hE: m_out = m_a;
            4'hF: begin
               m_halted = 1;
               hce = instr * 5 + 3;
            end
            default: ;
         endcase
         instr++;
      end
   endtask

   // Main sequence
   initial begin
      btn1_n = 1'b0; btn2_n = 1'b0; slide = 1'b0;
      h_btn1_n = 1'b0; h_btn2_n = 1'b1; h_slide = 1'b1;
      waitClocks(3);

      // Reset held with all inputs low
      for (int i = 0; i < 25; i++) begin
         waitClocks(1);
         checkOutput("reset_hold_led", int'(led), 63);
      end

      // Reset held while the other inputs wander
      for (int i = 0; i < 20; i++) begin
         btn2_n = 1'($urandom);
         slide  = 1'($urandom);
         waitClocks(1);
         checkOutput("reset_noise_led", int'(led), 63);
      end

      // Auto mode, one step per clock, run through the 255->0 wrap
      btn2_n = 1'b1; slide = 1'b1;
      waitClocks(4);
      btn1_n = 1'b1;
      waitClocks(2);
      for (int n = 1; n <= 3850; n++) begin
         waitClocks(1);
         checkOutput("auto_led", int'(led), ledOf(expOut(n)));
         checkOutput("auto_acc", int'(dut.u_core.a_q), expAcc(n));
         checkOutput("auto_carry", int'(dut.u_core.c_q), expFlag(n));
         checkOutput("auto_zero", int'(dut.u_core.z_q), expFlag(n));
         if (n == 3 || n == 18 || n == 33)
            checkOutput($sformatf("spec_out_ce%0d", n), int'(dut.u_core.out_q), (n - 3) / 15);
         if (n == 3835) begin
            checkOutput("wrap_carry", int'(dut.u_core.c_q), 1);
            checkOutput("wrap_zero", int'(dut.u_core.z_q), 1);
         end
         if (n == 3842) checkOutput("wrap_out_ff", int'(dut.u_core.out_q), 255);
         if (n == 3843) checkOutput("wrap_out_00", int'(dut.u_core.out_q), 0);
      end

      // Switch to manual mid-instruction: two more steps land while the switch synchronizes
      nce = 3850;
      slide = 1'b0;
      waitClocks(2);
      nce += 2;
      for (int i = 0; i < 5; i++) begin
         waitClocks(2);
         checkOutput("manual_idle_led", int'(led), ledOf(expOut(nce)));
         checkOutput("manual_idle_t", int'(dut.u_core.t_q), nce % 5);
      end

      // Random batches of manual presses
      for (int b = 0; b < 6; b++) begin
         int presses;
         presses = $urandom_range(1, 12);
         applyStimulus(presses);
         nce += presses;
         waitClocks(3);
         checkOutput("manual_led", int'(led), ledOf(expOut(nce)));
         checkOutput("manual_acc", int'(dut.u_core.a_q), expAcc(nce));
         checkOutput("manual_t", int'(dut.u_core.t_q), nce % 5);
      end

      // Park at T3 and reset mid-instruction
      begin
         int k;
         k = (8 - (nce % 5)) % 5;
         if (k > 0) applyStimulus(k);
         nce += k;
         waitClocks(8);
      end
      checkOutput("park_t", int'(dut.u_core.t_q), 3);
      checkOutput("park_led", int'(led), ledOf(expOut(nce)));
      btn1_n = 1'b0;
      waitClocks(2);
      checkOutput("pre_reset_t", int'(dut.u_core.t_q), 3);
      waitClocks(1);
      checkOutput("midreset_pc", int'(dut.u_core.pc_q), 0);
      checkOutput("midreset_t", int'(dut.u_core.t_q), 0);
      checkOutput("midreset_acc", int'(dut.u_core.a_q), 0);
      checkOutput("midreset_led", int'(led), 63);

      // Manual mode from reset: 18 presses reach OUT = 1
      waitClocks(3);
      btn1_n = 1'b1;
      waitClocks(3);
      applyStimulus(18);
      waitClocks(3);
      checkOutput("manual18_led", int'(led), 62);
      waitClocks(10);
      checkOutput("manual18_static_led", int'(led), 62);
      checkOutput("manual18_static_t", int'(dut.u_core.t_q), 3);

      // Halting program in auto mode
      runModel(haltCe);
      h_btn1_n = 1'b1;
      waitClocks(2);
      for (int n = 1; n <= haltCe + 40; n++) begin
         waitClocks(1);
         checkOutput("halt_flag", int'(dut_h.u_core.halted_q), (n >= haltCe) ? 1 : 0);
      end
      checkOutput("halt_acc", int'(dut_h.u_core.a_q), m_a);
      checkOutput("halt_pc", int'(dut_h.u_core.pc_q), m_pc);
      checkOutput("halt_carry", int'(dut_h.u_core.c_q), m_c);
      checkOutput("halt_zero", int'(dut_h.u_core.z_q), m_z);
      checkOutput("halt_led", int'(h_led), ledOf(m_out));
      checkOutput("halt_t", int'(dut_h.u_core.t_q), 3);
      h_btn1_n = 1'b0;
      waitClocks(3);
      checkOutput("halt_cleared", int'(dut_h.u_core.halted_q), 0);
      checkOutput("halt_reset_pc", int'(dut_h.u_core.pc_q), 0);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule

// File: doc/cpu8_top.md
# cpu8_top

Board-level top of the 8-bit accumulator CPU (SAP-1 class) for the 27 MHz FPGA board. It conditions the two active-low push-buttons and the slide switch, generates the CPU step enable (free-running or single-step), and runs a 16-byte program from internal RAM. The low 6 bits of the output register drive the six active-low board LEDs.

## Interface
- DIV_COUNT, default 13_500_000: system clocks per auto step; 1 = step every clock.
- clk  input  1  system clock; all logic on rising edge.
- btn1_n  input  1  reset button, active-low; internal rst = ~btn1_n after 2-FF sync; reset is synchronous and active-high.
- btn2_n  input  1  manual step button, active-low.
- slide_switch  input  1  1 = auto-step mode, 0 = manual-step mode.
- led  output  6  led[i] = ~out_reg[i], i = 0..5 (LED on when bit = 1).

## Operation
- Button inputs: 2-FF synchronizers; falling edge of synchronized btn2_n gives a 1-clock `step_pulse`.
- Step enable `ce`: auto mode, every DIV_COUNT clocks (divider counter cleared by rst); manual mode, `ce = step_pulse`; forced to 0 while halted.
- State: PC[3:0], MAR[3:0], IR[7:0], A[7:0], B[7:0], OUT[7:0], flags C and Z, microstep T[2:0] (0..4), halted bit, RAM 16x8.
- Reset: all registers, flags, T, halted, divider = 0. RAM is not reset; it is initialized at configuration: addr 0 = 0xE0 (OUT), 1 = 0x2F (ADD 15), 2 = 0x60 (JMP 0), 15 = 0x01, all others 0x00.
- Every instruction takes exactly 5 steps (T0..T4); on each `ce`, execute the current microstep, then T = (T==4) ? 0 : T+1.
- Fetch: T0 MAR<=PC; T1 IR<=RAM[MAR], PC<=PC+1 (4-bit wrap 15->0).
- Opcode = IR[7:4], operand n = IR[3:0]:
- 0x0 NOP: none.
- 0x1 LDA: T2 MAR<=n; T3 A<=RAM[MAR].
- 0x2 ADD / 0x3 SUB: T2 MAR<=n; T3 B<=RAM[MAR]; T4 A<=A+B (SUB: A+~B+1), C = carry out of bit 7, Z = (result==0); flags update only here.
- 0x4 STA: T2 MAR<=n; T3 RAM[MAR]<=A.
- 0x5 LDI: T2 A<={4'h0,n}.
- 0x6 JMP: T2 PC<=n. 0x7 JC: T2 PC<=n if C. 0x8 JZ: T2 PC<=n if Z.
- 0xE OUT: T2 OUT<=A.
- 0xF HLT: T2 halted<=1; steps stop; only rst clears.
- 0x9-0xD: NOP.
- All arithmetic mod 256.

## Timing
- Reset: led = 6'b111111 (OUT = 0) on the clock after rst is sampled; held for as long as btn1_n = 0, regardless of the other inputs.
- Input sync latency: 2 clocks from pin to internal rst/step.
- With DIV_COUNT = 1 and auto mode, count `ce` from the first after reset release: OUT<=0 at ce 3; A<=1 at ce 10; PC<=0 at ce 13; OUT<=1 at ce 18; afterwards OUT increments once every 15 ce, wrapping 255->0.
- LED change is visible the clock after the OUT register write.
- Mode switch mid-instruction: T and all registers persist; only the step source changes.
- Reset mid-instruction: abort, all state cleared at that edge.

## Structure
- Package cpu8_pkg: 4-bit opcode enum (NOP, LDA, ADD, SUB, STA, LDI, JMP, JC, JZ, OUT, HLT), T-state constants, RAM init constants.
- Sub-module cpu8_core (registers, ALU, RAM, microcode sequencer; inputs clk, rst, ce; output out_reg[7:0]). The top level holds the synchronizers, step edge detection, divider and LED inversion.

## Test plan
- btn1_n = 0, btn2_n = 0, slide_switch = 0 for 25 clocks -> led = 6'b111111 throughout, no change.
- DIV_COUNT = 1, auto, release reset -> OUT = 0 at ce 3, OUT = 1 at ce 18, OUT = 2 at ce 33.
- Manual mode, 18 btn2_n press/release pulses after reset -> led = 6'b111110; no pulses -> led static.
- Run 256 increments -> OUT wraps 0xFF->0x00, C = 1, Z = 1 after that ADD.
- RAM preload {0:LDI 5, 1:SUB 15, 2:JZ 4, 3:JMP 1, 4:HLT}, [15] = 1 -> halted with A = 0; further ce ignored until reset.
- Assert reset mid-instruction (T = 3) -> next clock PC = 0, T = 0, A = 0, led = 6'b111111.
